// File: rtl/decode_issue_stage_pkg.sv
// Shared types for the rv32i decode/issue stage: opcodes, mux selects,
// the control packet handed to EX, RV32M op encoding and the FSM states.
package decode_issue_stage_pkg;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011
    } rv32i_opcode_t;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        f3_add  = 3'b000,
        f3_sll  = 3'b001,
        f3_slt  = 3'b010,
        f3_sltu = 3'b011,
        f3_xor  = 3'b100,
        f3_sr   = 3'b101,
        f3_or   = 3'b110,
        f3_and  = 3'b111
    } arith_funct3_t;

    // Encoded so that aluop == funct3 for add/sll/xor/srl/or/and.
    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops_t;

    // RV32M operation, identical to the instruction funct3.
    typedef enum logic [2:0] {
        mul    = 3'b000,
        mulh   = 3'b001,
        mulhsu = 3'b010,
        mulhu  = 3'b011,
        div    = 3'b100,
        divu   = 3'b101,
        rem    = 3'b110,
        remu   = 3'b111
    } mduop_t;

    typedef enum logic {
        am1_rs1 = 1'b0,
        am1_pc  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        am2_i_imm = 3'd0,
        am2_u_imm = 3'd1,
        am2_b_imm = 3'd2,
        am2_s_imm = 3'd3,
        am2_j_imm = 3'd4,
        am2_rs2   = 3'd5
    } alumux2_sel_t;

    typedef enum logic {
        cm_rs2   = 1'b0,
        cm_i_imm = 1'b1
    } cmpmux_sel_t;

    typedef enum logic [3:0] {
        rf_alu_out  = 4'd0,
        rf_br_en    = 4'd1,
        rf_u_imm    = 4'd2,
        rf_lw       = 4'd3,
        rf_pc_plus4 = 4'd4,
        rf_lb       = 4'd5,
        rf_lbu      = 4'd6,
        rf_lh       = 4'd7,
        rf_lhu      = 4'd8,
        rf_mdu_out  = 4'd9
    } regfilemux_sel_t;

    localparam logic [6:0] funct7_mext = 7'b0000001;

    // Control packet travelling with the instruction into EX.
    typedef struct packed {
        rv32i_opcode_t   opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        alu_ops_t        aluop;
        branch_funct3_t  cmpop;
        alumux1_sel_t    alumux1_sel;
        alumux2_sel_t    alumux2_sel;
        cmpmux_sel_t     cmpmux_sel;
        regfilemux_sel_t regfilemux_sel;
        logic            load_regfile;
        logic            mem_read;
        logic            mem_write;
        logic            mdu;
        mduop_t          mduop;
    } rv32i_ctrl_packet_t;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_VALID = 2'd1,
        S_BLOCK = 2'd2
    } issue_state_t;

    // Block counter width; never narrower than one bit even if both latencies are 0.
    function automatic int cnt_width(input int mul_lat, input int div_lat);
        int m;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/decode_issue_stage_if.sv
// Upstream (IF/ID) and downstream (EX) handshake bundle of the decode stage.
// The stage itself uses the slave view; the surrounding pipeline uses master.
interface decode_issue_stage_if;
    import decode_issue_stage_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr_in;
    logic [31:0]        pc_in;
    logic               out_valid;
    logic               out_ready;
    rv32i_ctrl_packet_t ctrl_out;
    logic [31:0]        instr_out;
    logic [31:0]        pc_out;
    logic               illegal;
    logic               mdu_busy;

    modport slave (
        input  in_valid, instr_in, pc_in, out_ready,
        output in_ready, out_valid, ctrl_out, instr_out, pc_out, illegal, mdu_busy
    );

    modport master (
        output in_valid, instr_in, pc_in, out_ready,
        input  in_ready, out_valid, ctrl_out, instr_out, pc_out, illegal, mdu_busy
    );
endinterface

// File: rtl/decode_issue_stage_rv32_decoder.sv
// Purely combinational rv32i + RV32M decoder. Illegal encodings yield an
// all-zero packet so nothing downstream writes registers or memory.
module rv32_decoder
    import decode_issue_stage_pkg::*;
#(
    parameter bit M_EXT = 1'b1
) (
    input  logic [31:0]        i_instr,
    output rv32i_ctrl_packet_t o_ctrl,
    output logic               o_illegal,
    output logic               o_is_mul,
    output logic               o_is_div
);

    rv32i_opcode_t w_opcode;
    logic [2:0]    w_funct3;
    logic [6:0]    w_funct7;

    assign w_opcode = rv32i_opcode_t'(i_instr[6:0]);
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];

    // Build the control packet from opcode/funct3/funct7, then squash it when illegal.
    always_comb begin
        o_ctrl        = '0;
        o_illegal     = 1'b0;
        o_is_mul      = 1'b0;
        o_is_div      = 1'b0;
        o_ctrl.opcode = w_opcode;
        o_ctrl.rd     = i_instr[11:7];
        o_ctrl.rs1    = i_instr[19:15];
        o_ctrl.rs2    = i_instr[24:20];
        o_ctrl.funct3 = w_funct3;
        o_ctrl.funct7 = w_funct7;
        case (w_opcode)
            op_lui: begin
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.regfilemux_sel = rf_u_imm;
            end
            op_auipc: begin
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.alumux1_sel    = am1_pc;
                o_ctrl.alumux2_sel    = am2_u_imm;
                o_ctrl.regfilemux_sel = rf_alu_out;
            end
            op_jal: begin
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.alumux1_sel    = am1_pc;
                o_ctrl.alumux2_sel    = am2_j_imm;
                o_ctrl.regfilemux_sel = rf_pc_plus4;
            end
            op_jalr: begin
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.alumux1_sel    = am1_rs1;
                o_ctrl.alumux2_sel    = am2_i_imm;
                o_ctrl.regfilemux_sel = rf_pc_plus4;
            end
            op_br: begin
                o_ctrl.alumux1_sel = am1_pc;
                o_ctrl.alumux2_sel = am2_b_imm;
                o_ctrl.cmpmux_sel  = cm_rs2;
                case (w_funct3)
                    3'b010, 3'b011: o_illegal = 1'b1;
                    default:        o_ctrl.cmpop = branch_funct3_t'(w_funct3);
                endcase
            end
            op_load: begin
                o_ctrl.load_regfile = 1'b1;
                o_ctrl.mem_read     = 1'b1;
                o_ctrl.alumux2_sel  = am2_i_imm;
                case (w_funct3)
                    3'b000:  o_ctrl.regfilemux_sel = rf_lb;
                    3'b001:  o_ctrl.regfilemux_sel = rf_lh;
                    3'b010:  o_ctrl.regfilemux_sel = rf_lw;
                    3'b100:  o_ctrl.regfilemux_sel = rf_lbu;
                    3'b101:  o_ctrl.regfilemux_sel = rf_lhu;
                    default: o_illegal = 1'b1;
                endcase
            end
            op_store: begin
                o_ctrl.mem_write   = 1'b1;
                o_ctrl.alumux2_sel = am2_s_imm;
                if (w_funct3 > 3'b010) begin
                    o_illegal = 1'b1;
                end
            end
            op_imm: begin
                o_ctrl.load_regfile   = 1'b1;
                o_ctrl.alumux2_sel    = am2_i_imm;
                o_ctrl.regfilemux_sel = rf_alu_out;
                case (arith_funct3_t'(w_funct3))
                    f3_slt: begin
                        o_ctrl.cmpop          = blt;
                        o_ctrl.cmpmux_sel     = cm_i_imm;
                        o_ctrl.regfilemux_sel = rf_br_en;
                    end
                    f3_sltu: begin
                        o_ctrl.cmpop          = bltu;
                        o_ctrl.cmpmux_sel     = cm_i_imm;
                        o_ctrl.regfilemux_sel = rf_br_en;
                    end
                    f3_sr:   o_ctrl.aluop = w_funct7[5] ? alu_sra : alu_srl;
                    default: o_ctrl.aluop = alu_ops_t'(w_funct3);
                endcase
            end
            op_reg: begin
                if (w_funct7 == funct7_mext) begin
                    if (M_EXT) begin
                        o_ctrl.load_regfile   = 1'b1;
                        o_ctrl.regfilemux_sel = rf_mdu_out;
                        o_ctrl.mdu            = 1'b1;
                        o_ctrl.mduop          = mduop_t'(w_funct3);
                        o_is_mul              = ~w_funct3[2];
                        o_is_div              = w_funct3[2];
                    end else begin
                        o_illegal = 1'b1;
                    end
                end else begin
                    o_ctrl.load_regfile   = 1'b1;
                    o_ctrl.alumux2_sel    = am2_rs2;
                    o_ctrl.regfilemux_sel = rf_alu_out;
                    case (arith_funct3_t'(w_funct3))
                        f3_add:  o_ctrl.aluop = w_funct7[5] ? alu_sub : alu_add;
                        f3_sr:   o_ctrl.aluop = w_funct7[5] ? alu_sra : alu_srl;
                        f3_slt: begin
                            o_ctrl.cmpop          = blt;
                            o_ctrl.cmpmux_sel     = cm_rs2;
                            o_ctrl.regfilemux_sel = rf_br_en;
                        end
                        f3_sltu: begin
                            o_ctrl.cmpop          = bltu;
                            o_ctrl.cmpmux_sel     = cm_rs2;
                            o_ctrl.regfilemux_sel = rf_br_en;
                        end
                        default: o_ctrl.aluop = alu_ops_t'(w_funct3);
                    endcase
                end
            end
            default: o_illegal = 1'b1;
        endcase
        if (o_illegal) begin
            o_ctrl   = '0;
            o_is_mul = 1'b0;
            o_is_div = 1'b0;
        end
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Registered decode/issue stage between IF/ID and EX. Holds one decoded
// entry and, after an MDU op leaves, stalls issue for the unit's latency.
module decode_issue_stage
    import decode_issue_stage_pkg::*;
#(
    parameter bit M_EXT   = 1'b1,
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 33,
    parameter int CNT_W   = cnt_width(MUL_LAT, DIV_LAT)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    decode_issue_stage_if.slave  bus
);

    issue_state_t       r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_out_valid;
    logic               r_mdu_busy;
    rv32i_ctrl_packet_t r_ctrl;
    logic [31:0]        r_instr;
    logic [31:0]        r_pc;
    logic               r_illegal;
    logic               r_held_mul;
    logic               r_held_div;

    rv32i_ctrl_packet_t w_dec_ctrl;
    logic               w_dec_illegal;
    logic               w_dec_mul;
    logic               w_dec_div;
    logic               w_held_blocking;
    logic               w_in_ready;
    logic               w_load;

    rv32_decoder #(
        .M_EXT (M_EXT)
    ) u_decoder (
        .i_instr   (bus.instr_in),
        .o_ctrl    (w_dec_ctrl),
        .o_illegal (w_dec_illegal),
        .o_is_mul  (w_dec_mul),
        .o_is_div  (w_dec_div)
    );

    // A zero latency means that class never needs the stall.
    assign w_held_blocking = (r_held_mul && (MUL_LAT > 0)) || (r_held_div && (DIV_LAT > 0));

    // Ready is the only combinational output; it follows out_ready while an entry is held.
    always_comb begin
        w_in_ready = 1'b0;
        if (!rst) begin
            case (r_state)
                S_EMPTY: w_in_ready = 1'b1;
                S_VALID: w_in_ready = bus.out_ready && !w_held_blocking;
                default: w_in_ready = 1'b0;
            endcase
        end
    end

    assign w_load = bus.in_valid && w_in_ready && !flush;

    // Issue FSM: EMPTY/VALID handshake, BLOCK counts down the committed MDU op.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_EMPTY;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_mdu_busy  <= 1'b0;
        end else begin
            case (r_state)
                S_BLOCK: begin
                    if (r_cnt <= CNT_W'(1)) begin
                        r_state    <= S_EMPTY;
                        r_cnt      <= '0;
                        r_mdu_busy <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_VALID: begin
                    if (flush) begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end else if (bus.out_ready) begin
                        if (w_held_blocking) begin
                            r_state     <= S_BLOCK;
                            r_cnt       <= r_held_mul ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                            r_out_valid <= 1'b0;
                            r_mdu_busy  <= 1'b1;
                        end else if (!bus.in_valid) begin
                            r_state     <= S_EMPTY;
                            r_out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    if (!flush && bus.in_valid) begin
                        r_state     <= S_VALID;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_state     <= S_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Entry registers capture the decoder output whenever a new instruction is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl     <= '0;
            r_instr    <= '0;
            r_pc       <= '0;
            r_illegal  <= 1'b0;
            r_held_mul <= 1'b0;
            r_held_div <= 1'b0;
        end else if (w_load) begin
            r_ctrl     <= w_dec_ctrl;
            r_instr    <= bus.instr_in;
            r_pc       <= bus.pc_in;
            r_illegal  <= w_dec_illegal;
            r_held_mul <= w_dec_mul;
            r_held_div <= w_dec_div;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.mdu_busy  = r_mdu_busy;
    assign bus.ctrl_out  = r_ctrl;
    assign bus.instr_out = r_instr;
    assign bus.pc_out    = r_pc;
    assign bus.illegal   = r_illegal;

endmodule
